// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory stage: RV32I size codes,
// FSM states, exception causes and byte-lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    EXC_MISALIGN = 2'd0,
    EXC_ILLEGAL  = 2'd1,
    EXC_TIMEOUT  = 2'd2
  } lsu_exc_e;

  function automatic logic [3:0] be_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: be_mask = 4'b0001 << addr_lo;
      F3_H, F3_HU: be_mask = 4'b0011 << addr_lo;
      default:     be_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic f3_legal(input logic is_load, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = is_load;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = (addr_lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

  // Store data replicated across all lanes so the bus only needs byte enables.
  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3_B, F3_BU: store_wdata = {4{data[7:0]}};
      F3_H, F3_HU: store_wdata = {2{data[15:0]}};
      default:     store_wdata = data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Picks the addressed byte/half out of a load data word and sign/zero extends it.
// Purely combinational.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'd0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'd0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage of the pipeline: issues loads/stores on a valid/ready bus, stalls the
// execute register while a transaction is open, and registers the writeback/exception.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_waddr,
  output logic        lsu_stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [3:0]  dmem_req_be,
  output logic [31:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_data,
  output logic        mem_exc,
  output logic [1:0]  mem_exc_cause,
  output logic [31:0] mem_exc_addr
);

  lsu_state_e  state;
  logic [31:0] wdog;
  logic        lat_load;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [4:0]  lat_waddr;

  logic        is_mem, f3_ok, misal, issue, timeout_hit;
  logic        sel_load;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr, sel_data, load_val;

  assign is_mem      = ex_load | ex_store;
  assign f3_ok       = f3_legal(ex_load, ex_funct3);
  assign misal       = misaligned(ex_funct3, ex_alu_result[1:0]);
  assign issue       = (state == IDLE) && ex_valid && is_mem && f3_ok && !misal;
  assign timeout_hit = (TIMEOUT != 0) && (state != IDLE) && (wdog == TIMEOUT - 1);

  // In IDLE the request is driven straight from the pipeline register; afterwards
  // from the latched copy so fields stay stable while the bus holds off.
  assign sel_load = (state == IDLE) ? ex_load       : lat_load;
  assign sel_f3   = (state == IDLE) ? ex_funct3     : lat_f3;
  assign sel_addr = (state == IDLE) ? ex_alu_result : lat_addr;
  assign sel_data = (state == IDLE) ? ex_rs2_data   : lat_data;

  assign dmem_req_valid = issue | ((state == REQ) && !timeout_hit);
  assign dmem_req_we    = dmem_req_valid && !sel_load;
  assign dmem_req_addr  = {sel_addr[31:2], 2'b00};
  assign dmem_req_be    = be_mask(sel_f3, sel_addr[1:0]);
  assign dmem_req_wdata = store_wdata(sel_f3, sel_data);

  always_comb begin
    lsu_stall = 1'b0;
    case (state)
      IDLE:    lsu_stall = issue && (ex_load || !dmem_req_ready);
      REQ:     lsu_stall = !timeout_hit && (lat_load || !dmem_req_ready);
      WAIT:    lsu_stall = !timeout_hit && !dmem_rsp_valid;
      default: lsu_stall = 1'b0;
    endcase
  end

  lsu_load_align u_align (
    .rdata   (dmem_rsp_rdata),
    .funct3  (lat_f3),
    .addr_lo (lat_addr[1:0]),
    .data    (load_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wdog          <= 32'd0;
      lat_load      <= 1'b0;
      lat_f3        <= 3'd0;
      lat_addr      <= 32'd0;
      lat_data      <= 32'd0;
      lat_waddr     <= 5'd0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_waddr      <= 5'd0;
      wb_data       <= 32'd0;
      mem_exc       <= 1'b0;
      mem_exc_cause <= 2'd0;
      mem_exc_addr  <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      mem_exc  <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= 32'd0;
          if (ex_valid && !is_mem) begin
            wb_valid <= 1'b1;
            wb_we    <= (ex_waddr != 5'd0);
            wb_waddr <= ex_waddr;
            wb_data  <= ex_alu_result;
          end else if (ex_valid && (!f3_ok || misal)) begin
            mem_exc       <= 1'b1;
            mem_exc_cause <= f3_ok ? EXC_MISALIGN : EXC_ILLEGAL;
            mem_exc_addr  <= ex_alu_result;
          end else if (issue) begin
            lat_load  <= ex_load;
            lat_f3    <= ex_funct3;
            lat_addr  <= ex_alu_result;
            lat_data  <= ex_rs2_data;
            lat_waddr <= ex_waddr;
            if (ex_load)
              state <= dmem_req_ready ? WAIT : REQ;
            else if (!dmem_req_ready)
              state <= REQ;
          end
        end
        REQ, WAIT: begin
          wdog <= wdog + 32'd1;
          if (timeout_hit) begin
            state         <= IDLE;
            mem_exc       <= 1'b1;
            mem_exc_cause <= EXC_TIMEOUT;
            mem_exc_addr  <= lat_addr;
          end else if (state == REQ) begin
            if (dmem_req_ready)
              state <= lat_load ? WAIT : IDLE;
          end else if (dmem_rsp_valid) begin
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_we    <= (lat_waddr != 5'd0);
            wb_waddr <= lat_waddr;
            wb_data  <= load_val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized and directed bench for lsu_mem_stage against an arithmetic reference model.
module tb_lsu_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_rs2_data;
  logic [4:0]  ex_waddr;
  logic        lsu_stall;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;
  logic        mem_exc;
  logic [1:0]  mem_exc_cause;
  logic [31:0] mem_exc_addr;

  int checks = 0;
  int passes = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wdata, last_addr;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_waddr(ex_waddr),
    .lsu_stall(lsu_stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_be(dmem_req_be), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_data(wb_data),
    .mem_exc(mem_exc), .mem_exc_cause(mem_exc_cause), .mem_exc_addr(mem_exc_addr)
  );

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    longint v;
    int off;
    off = int'(a % 32'd4);
    case (f3)
      3'd0: begin v = longint'((w >> (8 * off)) & 32'hFF); if (v >= 128) v = v - 256; end
      3'd4: v = longint'((w >> (8 * off)) & 32'hFF);
      3'd1: begin v = longint'((w >> (8 * off)) & 32'hFFFF); if (v >= 32768) v = v - 65536; end
      3'd5: v = longint'((w >> (8 * off)) & 32'hFFFF);
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  // One instruction presented to the stage; the bench plays the bus with the given delays.
  task automatic do_op(input string nm, input bit v, input bit ld, input bit st,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] wa, input int rq_dly, input int rs_dly,
                       input logic [31:0] rdata);
    bit is_mem, legal, mis, exp_req, exp_wb, exp_exc, exp_to, accepted, was_acc, stall_s, fire;
    int size, off, comp, exp_cyc, cyc, reqcnt, rspcnt;
    logic [1:0]  exp_cause;
    logic [3:0]  exp_be;
    logic [31:0] exp_wbd, exp_wdata;

    is_mem   = v && (ld || st);
    legal    = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    size     = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    off      = int'(a % 32'd4);
    mis      = (off % size) != 0;
    exp_req  = is_mem && legal && !mis;
    comp     = ld ? rq_dly + rs_dly + 1 : rq_dly;
    exp_to   = exp_req && (comp >= TO);
    exp_cyc  = exp_req ? 1 + (exp_to ? TO : comp) : 1;
    exp_wb   = (v && !(ld || st)) || (exp_req && ld && !exp_to);
    exp_wbd  = ld ? model_load(f3, a, rdata) : a;
    exp_exc  = (is_mem && (!legal || mis)) || exp_to;
    exp_cause = !legal ? 2'd1 : mis ? 2'd0 : 2'd2;
    exp_be   = 4'(((1 << size) - 1) << off);
    exp_wdata = (size == 1) ? 32'(d[7:0]) * 32'h0101_0101 :
                (size == 2) ? 32'(d[15:0]) * 32'h0001_0001 : d;

    ex_valid = v; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_alu_result = a; ex_rs2_data = d; ex_waddr = wa;
    accepted = 0; reqcnt = 0; rspcnt = 0; cyc = 1;
    forever begin
      dmem_req_ready = !accepted && (reqcnt >= rq_dly);
      dmem_rsp_valid = accepted && ld && (rspcnt >= rs_dly);
      dmem_rsp_rdata = rdata;
      #1;
      if (cyc == 1) begin
        checks++;
        if (dmem_req_valid !== exp_req)
          $display("FAIL %s req_valid: got %b want %b", nm, dmem_req_valid, exp_req);
        else passes++;
      end
      if (dmem_req_valid && accepted) begin
        checks++;
        $display("FAIL %s req_after_accept: got req_valid 1 want 0", nm);
      end else if (dmem_req_valid) begin
        last_be = dmem_req_be; last_wdata = dmem_req_wdata; last_addr = dmem_req_addr;
        checks++;
        if (dmem_req_addr !== (a & 32'hFFFF_FFFC))
          $display("FAIL %s req_addr: got %h want %h", nm, dmem_req_addr, a & 32'hFFFF_FFFC);
        else passes++;
        checks++;
        if (dmem_req_we !== !ld) $display("FAIL %s req_we: got %b want %b", nm, dmem_req_we, !ld);
        else passes++;
        if (!ld) begin
          checks++;
          if (dmem_req_be !== exp_be) $display("FAIL %s req_be: got %b want %b", nm, dmem_req_be, exp_be);
          else passes++;
          checks++;
          if (dmem_req_wdata !== exp_wdata)
            $display("FAIL %s req_wdata: got %h want %h", nm, dmem_req_wdata, exp_wdata);
          else passes++;
        end
      end
      stall_s = lsu_stall;
      checks++;
      if (stall_s !== (cyc != exp_cyc))
        $display("FAIL %s stall cycle %0d: got %b want %b", nm, cyc, stall_s, cyc != exp_cyc);
      else passes++;
      fire = dmem_req_valid && dmem_req_ready;
      was_acc = accepted;
      @(posedge clk);
      if (was_acc) rspcnt++;
      if (fire) accepted = 1;
      else if (dmem_req_valid) reqcnt++;
      if (!stall_s) break;
      if (cyc > exp_cyc + 4) begin
        checks++;
        $display("FAIL %s stall_never_dropped: got %0d cycles want %0d", nm, cyc, exp_cyc);
        break;
      end
      cyc++;
      @(negedge clk);
    end
    @(negedge clk);
    dmem_req_ready = 0; dmem_rsp_valid = 0; ex_valid = 0;
    #1;
    checks++;
    if (wb_valid !== exp_wb) $display("FAIL %s wb_valid: got %b want %b", nm, wb_valid, exp_wb);
    else passes++;
    if (exp_wb) begin
      checks++;
      if (wb_data !== exp_wbd) $display("FAIL %s wb_data: got %h want %h", nm, wb_data, exp_wbd);
      else passes++;
      checks++;
      if (wb_waddr !== wa || wb_we !== (wa != 5'd0))
        $display("FAIL %s wb_waddr/we: got %0d/%b want %0d/%b", nm, wb_waddr, wb_we, wa, wa != 5'd0);
      else passes++;
    end
    checks++;
    if (mem_exc !== exp_exc) $display("FAIL %s mem_exc: got %b want %b", nm, mem_exc, exp_exc);
    else passes++;
    if (exp_exc) begin
      checks++;
      if (mem_exc_cause !== exp_cause || mem_exc_addr !== a)
        $display("FAIL %s exc cause/addr: got %0d/%h want %0d/%h", nm, mem_exc_cause, mem_exc_addr, exp_cause, a);
      else passes++;
    end
  endtask

  task automatic test_reset();
    rst = 1; ex_valid = 0; ex_load = 0; ex_store = 0; ex_funct3 = 0;
    ex_alu_result = 0; ex_rs2_data = 0; ex_waddr = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({wb_valid, wb_we, wb_waddr, wb_data, mem_exc, mem_exc_cause, mem_exc_addr} !== '0)
      $display("FAIL reset_regs: got wb %b/%b/%h/%h exc %b/%h/%h want all 0",
               wb_valid, wb_we, wb_waddr, wb_data, mem_exc, mem_exc_cause, mem_exc_addr);
    else passes++;
    checks++;
    if (dmem_req_valid !== 1'b0 || lsu_stall !== 1'b0)
      $display("FAIL reset_bus: got req_valid %b stall %b want 0 0", dmem_req_valid, lsu_stall);
    else passes++;
    rst = 0;
  endtask

  task automatic test_directed();
    do_op("alu", 1, 0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0);
    checks++;
    if (wb_data !== 32'h1234) $display("FAIL alu_const: got %h want 00001234", wb_data);
    else passes++;
    do_op("sb", 1, 0, 1, 3'd0, 32'h103, 32'hAB, 5'd0, 0, 0, 32'h0);
    checks++;
    if (last_be !== 4'b1000 || last_wdata !== 32'hABAB_ABAB || last_addr !== 32'h100)
      $display("FAIL sb_const: got be %b wdata %h addr %h want 1000 abababab 00000100",
               last_be, last_wdata, last_addr);
    else passes++;
    do_op("lh", 1, 1, 0, 3'd1, 32'h202, 32'h0, 5'd7, 2, 0, 32'h8001_0000);
    checks++;
    if (wb_data !== 32'hFFFF_8001) $display("FAIL lh_const: got %h want ffff8001", wb_data);
    else passes++;
    do_op("lhu", 1, 1, 0, 3'd5, 32'h202, 32'h0, 5'd8, 0, 1, 32'h8001_0000);
    checks++;
    if (wb_data !== 32'h0000_8001) $display("FAIL lhu_const: got %h want 00008001", wb_data);
    else passes++;
  endtask

  task automatic test_exceptions();
    do_op("lw_misaligned", 1, 1, 0, 3'd2, 32'h101, 32'h0, 5'd4, 0, 0, 32'h0);
    do_op("ld_illegal_f3", 1, 1, 0, 3'd3, 32'h200, 32'h0, 5'd4, 0, 0, 32'h0);
    do_op("st_illegal_bu", 1, 0, 1, 3'd4, 32'h200, 32'h0, 5'd4, 0, 0, 32'h0);
    do_op("sh_misaligned", 1, 0, 1, 3'd1, 32'h203, 32'h0, 5'd4, 0, 0, 32'h0);
    do_op("ld_and_st_load", 1, 1, 1, 3'd4, 32'h7, 32'h0, 5'd2, 1, 0, 32'h00FE_0000);
  endtask

  task automatic test_timeout();
    do_op("timeout_load", 1, 1, 0, 3'd2, 32'h300, 32'h0, 5'd6, 0, 1000, 32'h0);
    do_op("timeout_store", 1, 0, 1, 3'd2, 32'h304, 32'h55, 5'd6, 1000, 0, 32'h0);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_alu0", 1, 0, 0, 3'd0, 32'hCAFE_0001, 32'h0, 5'd1, 0, 0, 32'h0);
    do_op("b2b_sw", 1, 0, 1, 3'd2, 32'h400, 32'h1122_3344, 5'd0, 0, 0, 32'h0);
    do_op("b2b_alu1", 1, 0, 0, 3'd0, 32'hCAFE_0002, 32'h0, 5'd0, 0, 0, 32'h0);
    do_op("b2b_lb", 1, 1, 0, 3'd0, 32'h401, 32'h0, 5'd31, 0, 0, 32'h0000_F000);
  endtask

  task automatic test_rst_in_wait();
    do_op("pre_rst_alu", 1, 0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0, 5'd9, 0, 0, 32'h0);
    ex_valid = 1; ex_load = 1; ex_store = 0; ex_funct3 = 3'd2;
    ex_alu_result = 32'h40; ex_waddr = 5'd3; dmem_req_ready = 1;
    @(posedge clk); @(negedge clk);
    dmem_req_ready = 0;
    #1;
    checks++;
    if (lsu_stall !== 1'b1 || dmem_req_valid !== 1'b0)
      $display("FAIL wait_state: got stall %b req_valid %b want 1 0", lsu_stall, dmem_req_valid);
    else passes++;
    @(posedge clk); @(negedge clk);
    rst = 1; ex_valid = 0;
    @(posedge clk); @(negedge clk);
    rst = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (lsu_stall !== 1'b0 || dmem_req_valid !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 32'h0 ||
        wb_waddr !== 5'd0 || mem_exc !== 1'b0)
      $display("FAIL rst_in_wait: got stall %b req %b wb %b/%h/%0d exc %b want all 0",
               lsu_stall, dmem_req_valid, wb_valid, wb_data, wb_waddr, mem_exc);
    else passes++;
    @(posedge clk); @(negedge clk);
    dmem_rsp_valid = 0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || mem_exc !== 1'b0)
      $display("FAIL late_rsp: got wb_valid %b mem_exc %b want 0 0", wb_valid, mem_exc);
    else passes++;
    do_op("post_rst_alu", 1, 0, 0, 3'd0, 32'h0000_0777, 32'h0, 5'd12, 0, 0, 32'h0);
  endtask

  task automatic test_random();
    logic [2:0] lf [5];
    bit v, ld, st;
    int k, rq, rs;
    logic [2:0]  f3;
    logic [31:0] a, d, rd;
    logic [4:0]  wa;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 200; i++) begin
      v  = ($urandom_range(0, 9) != 0);
      k  = $urandom_range(0, 3);
      ld = (k == 1) || (k == 3);
      st = (k == 2) || (k == 3);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = ld ? lf[$urandom_range(0, 4)] : lf[$urandom_range(0, 2)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      d  = $urandom; rd = $urandom; wa = 5'($urandom_range(0, 31));
      if (ld) begin rq = $urandom_range(0, 2); rs = $urandom_range(0, 2 - rq); end
      else begin rq = $urandom_range(0, 3); rs = 0; end
      do_op("random", v, ld, st, f3, a, d, wa, rq, rs, rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_exceptions();
    test_timeout();
    test_back_to_back();
    test_rst_in_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
